trace_dump_ctrl: RTL and testbench
==================================

# trace_dump_ctrl

Parametrised trace dump engine for the capture RAM. It replaces the fixed 3-channel, 8-bit dump path. On command it reads one channel, or every channel in sequence, from the circular capture RAM, oldest sample first. Each sample gets a per-channel offset/gain correction with saturation and is streamed to the UART transmit path over a valid/ready handshake. It sits between the command processor (which supplies offset/gain on request), the per-channel capture RAMs, and the UART transmitter.

## Interface
Parameters:
- NCH, 3: number of capture channels (≥1)
- DW, 8: sample width
- AW, 9: RAM address width; depth = 2^AW
- GW, 8: gain width, unsigned fixed point with GW-1 fraction bits (1.0 = 2^(GW-1))

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; asynchronous, active-low
- dump_start  in  1  one-cycle start pulse; ignored while busy
- dump_all  in  1  sampled with dump_start: 1 = dump channels 0..NCH-1 in order; 0 = dump dump_chan only
- dump_chan  in  $clog2(NCH) (min 1)  channel for single dump; values ≥NCH are clamped to NCH-1
- abort  in  1  synchronous cancel
- trace_end  in  AW  address of newest sample; sampled with dump_start
- og_req  out  1  offset/gain request, held until og_valid
- og_chan  out  $clog2(NCH)  channel being requested
- og_valid  in  1  og_offset/og_gain valid (one-cycle pulse)
- og_offset  in  DW  signed offset
- og_gain  in  GW  unsigned gain
- ram_en  out  1  RAM read enable
- ram_addr  out  AW  RAM read address
- ram_rdata  in  NCH*DW  all channel read data; channel c at [c*DW +: DW]; 1-cycle read latency
- tx_valid  out  1  tx_data valid
- tx_data  out  DW  corrected sample
- tx_ready  in  1  transmitter accepts
- busy  out  1  dump in progress (not IDLE)
- done  out  1  one-cycle pulse at dump completion
- cur_chan  out  $clog2(NCH)  channel currently dumping

## Operation
- States: IDLE, OG_REQ, RD, CAP, SEND.
- **IDLE:**
  - On dump_start, latch trace_end, the mode and the start channel (0 if dump_all, else clamped dump_chan).
  - Go to OG_REQ.
- **OG_REQ:**
  - og_req=1 with og_chan=cur_chan.
  - On og_valid, latch offset/gain, set addr=trace_end+1 (mod 2^AW), set sample count=0, go to RD.
- **RD:** ram_en=1, ram_addr=addr; go to CAP.
- **CAP:**
  - Select the cur_chan slice of ram_rdata and apply the correction.
  - Register the result into tx_data with tx_valid=1; go to SEND.
- **SEND:**
  - tx_data and tx_valid are held stable until tx_ready.
  - On tx_valid&tx_ready with count<2^AW-1: addr+1 (wraps), count+1, go to RD.
  - On the last sample (count=2^AW-1, i.e. address trace_end sent):
    - if dump_all and cur_chan<NCH-1: cur_chan+1, go to OG_REQ;
    - otherwise pulse done and go to IDLE.
- Every dump sends all 2^AW samples per channel, trace_end+1 through trace_end inclusive.
- **Correction:**
  - sum = rdata (unsigned) + offset (signed), clamped to [0, 2^DW-1].
  - prod = sum*gain, DW+GW bits.
  - result = prod >> (GW-1), clamped to 2^DW-1.
- **abort:** in any non-IDLE state it forces IDLE next cycle. tx_valid, og_req and ram_en drop immediately after, and no done pulse is issued. abort has priority over every simultaneous event, including the final handshake.
- dump_start while busy is ignored. dump_start and abort in the same cycle in IDLE: abort wins, no dump.
- Reset values: all outputs 0; state IDLE; internal address, count and channel registers 0.

## Timing
- dump_start at cycle T → og_req=1 at T+1.
- og_valid at cycle U → ram_en at U+1 → tx_valid at U+3.
- Handshake at cycle V → next sample's tx_valid at V+3. Steady-state throughput is 1 sample per 3 cycles with tx_ready held high.
- done is asserted in the cycle after the final handshake, concurrent with the return to IDLE. busy drops in the same cycle.
- og_valid is only honoured in OG_REQ. tx_ready is only honoured in SEND.

## Structure
- Package trace_pkg:
  - state enum trace_dump_state_t;
  - function sat_add_s(unsigned, signed) for the clamped offset add.
- Sub-module og_corrector (purely combinational: DW, GW parameters; rdata, offset, gain → result), instantiated once in the CAP stage.

## Test plan
Bench parameters: NCH=3, DW=8, AW=4, GW=8.
- **Single-channel dump:** dump_chan=1, trace_end=5, offset 0, gain 0x80, tx_ready=1 → exactly 16 samples, ch1 addresses 6,7,…,15,0,…,5; done pulses once; busy low afterwards.
- **Correction saturation:**
  - rdata 0xF0, offset 0x20, gain 0x80 → 0xFF;
  - rdata 0x10, offset 0xE0 → 0x00;
  - rdata 0x40, offset 0, gain 0x40 → 0x20;
  - rdata 0x90, offset 0, gain 0xFF → 0xFF.
- **dump_all:** og_req is issued 3 times with og_chan 0,1,2; 48 samples total; each channel uses its own offset/gain; a single done pulse at the end.
- **Backpressure:** tx_ready toggled pseudo-randomly → tx_data stable while tx_valid&!tx_ready; no sample is lost or duplicated; sequence matches the reference model.
- **Abort:**
  - abort mid-SEND on sample 7 → IDLE next cycle, tx_valid=0, no done;
  - a new dump_start afterwards runs a complete dump.
- **Asynchronous reset mid-dump and ignored restart:**
  - asynchronous reset mid-dump → all outputs 0 immediately;
  - dump_start while busy → no effect on the running dump.

Source files
------------

// File: rtl/trace_pkg.sv
// trace_pkg: shared types and helpers for the trace dump engine.
// Provides the dump FSM state enum and the clamped signed-offset add.
package trace_pkg;

  typedef enum logic [2:0] {
    IDLE,
    OG_REQ,
    RD,
    CAP,
    SEND
  } trace_dump_state_t;

  // a: zero-extended sample, b: sign-extended offset.
  // Result clamped to [0, maxv].
  function automatic logic [31:0] sat_add_s(
    input logic        [31:0] a,
    input logic signed [31:0] b,
    input logic        [31:0] maxv
  );
    logic signed [33:0] s;
    s = $signed({2'b00, a}) + 34'(b);
    if (s < 0)
      return '0;
    else if (s > $signed({2'b00, maxv}))
      return maxv;
    else
      return s[31:0];
  endfunction

endpackage

// File: rtl/trace_dump_ctrl_og_corrector.sv
// og_corrector: combinational offset/gain correction of one sample.
// rdata + signed offset (clamped), times gain >> (GW-1), clamped.
module og_corrector
  import trace_pkg::*;
#(
  parameter int DW = 8,
  parameter int GW = 8
) (
  input  logic [DW-1:0] rdata,
  input  logic [DW-1:0] offset,
  input  logic [GW-1:0] gain,
  output logic [DW-1:0] result
);

  localparam int PW = DW + GW;
  localparam logic [31:0] MAXV = 32'((64'(1) << DW) - 1);

  logic [31:0]   sum32;
  logic [DW-1:0] sum;
  logic [PW-1:0] prod;
  logic [PW-1:0] shr;

  always_comb begin
    sum32  = sat_add_s(32'(rdata), 32'($signed(offset)), MAXV);
    sum    = sum32[DW-1:0];
    prod   = PW'(sum) * PW'(gain);
    shr    = prod >> (GW - 1);
    result = (shr > PW'(MAXV)) ? '1 : shr[DW-1:0];
  end

endmodule

// File: rtl/trace_dump_ctrl.sv
// trace_dump_ctrl: dumps one or all capture channels oldest-first,
// fetching offset/gain per channel and streaming corrected samples.
module trace_dump_ctrl
  import trace_pkg::*;
#(
  parameter int NCH = 3,
  parameter int DW  = 8,
  parameter int AW  = 9,
  parameter int GW  = 8,
  localparam int CW = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              dump_start,
  input  logic              dump_all,
  input  logic [CW-1:0]     dump_chan,
  input  logic              abort,
  input  logic [AW-1:0]     trace_end,
  output logic              og_req,
  output logic [CW-1:0]     og_chan,
  input  logic              og_valid,
  input  logic [DW-1:0]     og_offset,
  input  logic [GW-1:0]     og_gain,
  output logic              ram_en,
  output logic [AW-1:0]     ram_addr,
  input  logic [NCH*DW-1:0] ram_rdata,
  output logic              tx_valid,
  output logic [DW-1:0]     tx_data,
  input  logic              tx_ready,
  output logic              busy,
  output logic              done,
  output logic [CW-1:0]     cur_chan
);

  localparam logic [CW-1:0] LAST_CH = CW'(NCH - 1);

  trace_dump_state_t state_q, state_d;
  logic              all_q, all_d;
  logic [CW-1:0]     chan_q, chan_d;
  logic [AW-1:0]     end_q, end_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic [AW-1:0]     cnt_q, cnt_d;
  logic [DW-1:0]     off_q, off_d;
  logic [GW-1:0]     gain_q, gain_d;
  logic [DW-1:0]     data_q, data_d;
  logic              done_q, done_d;

  logic [DW-1:0]     cap_sample;
  logic [DW-1:0]     cap_result;

  assign cap_sample = ram_rdata[int'(chan_q)*DW +: DW];

  og_corrector #(
    .DW (DW),
    .GW (GW)
  ) u_corr (
    .rdata  (cap_sample),
    .offset (off_q),
    .gain   (gain_q),
    .result (cap_result)
  );

  always_comb begin
    state_d = state_q;
    all_d   = all_q;
    chan_d  = chan_q;
    end_d   = end_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    off_d   = off_q;
    gain_d  = gain_q;
    data_d  = data_q;
    done_d  = 1'b0;
    // abort outranks every other event, even the last handshake
    if (abort) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (dump_start) begin
            all_d   = dump_all;
            end_d   = trace_end;
            if (dump_all)
              chan_d = '0;
            else if (dump_chan > LAST_CH)
              chan_d = LAST_CH;
            else
              chan_d = dump_chan;
            state_d = OG_REQ;
          end
        end
        OG_REQ: begin
          if (og_valid) begin
            off_d   = og_offset;
            gain_d  = og_gain;
            addr_d  = end_q + 1'b1;
            cnt_d   = '0;
            state_d = RD;
          end
        end
        RD: state_d = CAP;
        CAP: begin
          data_d  = cap_result;
          state_d = SEND;
        end
        SEND: begin
          if (tx_ready) begin
            if (cnt_q != '1) begin
              addr_d  = addr_q + 1'b1;
              cnt_d   = cnt_q + 1'b1;
              state_d = RD;
            end else if (all_q && chan_q != LAST_CH) begin
              chan_d  = chan_q + 1'b1;
              state_d = OG_REQ;
            end else begin
              done_d  = 1'b1;
              state_d = IDLE;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      all_q   <= 1'b0;
      chan_q  <= '0;
      end_q   <= '0;
      addr_q  <= '0;
      cnt_q   <= '0;
      off_q   <= '0;
      gain_q  <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      all_q   <= all_d;
      chan_q  <= chan_d;
      end_q   <= end_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      off_q   <= off_d;
      gain_q  <= gain_d;
      data_q  <= data_d;
      done_q  <= done_d;
    end
  end

  assign og_req   = (state_q == OG_REQ);
  assign og_chan  = chan_q;
  assign ram_en   = (state_q == RD);
  assign ram_addr = addr_q;
  assign tx_valid = (state_q == SEND);
  assign tx_data  = data_q;
  assign busy     = (state_q != IDLE);
  assign done     = done_q;
  assign cur_chan = chan_q;

endmodule

// File: tb/tb_trace_dump_ctrl.sv
// tb_trace_dump_ctrl: directed bench for trace_dump_ctrl.
// Models capture RAM, offset/gain responder and UART sink.
module tb_trace_dump_ctrl;

  localparam int NCH = 3;
  localparam int DW  = 8;
  localparam int AW  = 4;
  localparam int GW  = 8;
  localparam int CW  = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              dump_start = 1'b0;
  logic              dump_all = 1'b0;
  logic [CW-1:0]     dump_chan = '0;
  logic              abort = 1'b0;
  logic [AW-1:0]     trace_end = '0;
  logic              og_req;
  logic [CW-1:0]     og_chan;
  logic              og_valid = 1'b0;
  logic [DW-1:0]     og_offset = '0;
  logic [GW-1:0]     og_gain = '0;
  logic              ram_en;
  logic [AW-1:0]     ram_addr;
  logic [NCH*DW-1:0] ram_rdata = '0;
  logic              tx_valid;
  logic [DW-1:0]     tx_data;
  logic              tx_ready = 1'b0;
  logic              busy;
  logic              done;
  logic [CW-1:0]     cur_chan;

  int checks = 0;
  int passed = 0;

  logic [7:0] mem [NCH][16];
  logic [7:0] off_tab [NCH];
  logic [7:0] gain_tab [NCH];
  logic [7:0] got [$];
  logic [7:0] exp_q [$];
  int         og_log [$];
  int         done_cnt = 0;
  int         stab_err = 0;
  int         rdy_mode = 0;
  logic       og_auto = 1'b1;
  logic       og_man = 1'b0;
  logic       chk_stable = 1'b0;
  logic       hold_pend = 1'b0;
  logic [7:0] hold_data = '0;

  trace_dump_ctrl #(
    .NCH (NCH),
    .DW  (DW),
    .AW  (AW),
    .GW  (GW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .dump_start (dump_start),
    .dump_all   (dump_all),
    .dump_chan  (dump_chan),
    .abort      (abort),
    .trace_end  (trace_end),
    .og_req     (og_req),
    .og_chan    (og_chan),
    .og_valid   (og_valid),
    .og_offset  (og_offset),
    .og_gain    (og_gain),
    .ram_en     (ram_en),
    .ram_addr   (ram_addr),
    .ram_rdata  (ram_rdata),
    .tx_valid   (tx_valid),
    .tx_data    (tx_data),
    .tx_ready   (tx_ready),
    .busy       (busy),
    .done       (done),
    .cur_chan   (cur_chan)
  );

  always #5 clk = ~clk;

  // capture RAM, one-cycle read latency
  always @(posedge clk)
    if (ram_en)
      ram_rdata <= {mem[2][ram_addr], mem[1][ram_addr], mem[0][ram_addr]};

  // input drivers, updated just after the rising edge
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0: tx_ready = 1'b1;
      1: tx_ready = 1'($urandom_range(0, 1));
      3: tx_ready = (got.size() < 7);
      default: tx_ready = 1'b0;
    endcase
    og_valid = og_auto ? og_req : og_man;
    if (og_valid) begin
      og_offset = off_tab[og_chan];
      og_gain   = gain_tab[og_chan];
    end
  end

  // monitor on the falling edge
  always @(negedge clk) begin
    if (!rst_n) begin
      hold_pend = 1'b0;
    end else begin
      if (chk_stable && hold_pend && !(tx_valid && tx_data == hold_data))
        stab_err++;
      hold_pend = tx_valid && !tx_ready;
      hold_data = tx_data;
      if (tx_valid && tx_ready) got.push_back(tx_data);
      if (done) done_cnt++;
      if (og_valid && og_req) og_log.push_back(int'(og_chan));
    end
  end

  function automatic logic [7:0] corr(logic [7:0] r, logic [7:0] o, logic [7:0] g);
    int s;
    int p;
    s = int'(r) + int'($signed(o));
    if (s < 0) s = 0;
    if (s > 255) s = 255;
    p = (s * int'(g)) / 128;
    if (p > 255) p = 255;
    return p[7:0];
  endfunction

  task automatic build_exp(input logic all, input int ch, input int te);
    int first;
    int last;
    exp_q.delete();
    if (ch > NCH - 1) ch = NCH - 1;
    first = all ? 0 : ch;
    last  = all ? NCH - 1 : ch;
    for (int c = first; c <= last; c++)
      for (int i = 0; i < 16; i++)
        exp_q.push_back(corr(mem[c][(te + 1 + i) % 16], off_tab[c], gain_tab[c]));
  endtask

  task automatic fill_pattern();
    for (int c = 0; c < NCH; c++)
      for (int a = 0; a < 16; a++)
        mem[c][a] = 8'(c * 16 + a);
  endtask

  task automatic run_dump(input logic all, input logic [CW-1:0] ch,
                          input logic [AW-1:0] te, input string tag);
    int n;
    got.delete();
    og_log.delete();
    done_cnt = 0;
    @(negedge clk);
    dump_start = 1'b1;
    dump_all   = all;
    dump_chan  = ch;
    trace_end  = te;
    @(negedge clk);
    dump_start = 1'b0;
    n = 0;
    while (busy && n < 3000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (busy) $display("FAIL %s_timeout busy=%0b want 0", tag, busy);
    else passed++;
    @(negedge clk);
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if ({og_req, ram_en, tx_valid, busy, done} !== 5'b0)
      $display("FAIL reset_ctl got=%b want 00000", {og_req, ram_en, tx_valid, busy, done});
    else passed++;
    checks++;
    if ({tx_data, ram_addr, og_chan, cur_chan} !== '0)
      $display("FAIL reset_data got=%h want 0", {tx_data, ram_addr, og_chan, cur_chan});
    else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_latency();
    fill_pattern();
    og_auto = 1'b0;
    rdy_mode = 2;
    done_cnt = 0;
    @(negedge clk);
    dump_start = 1'b1;
    dump_all   = 1'b0;
    dump_chan  = 2'd2;
    trace_end  = 4'd15;
    @(negedge clk);
    dump_start = 1'b0;
    checks++;
    if (!(og_req === 1'b1 && og_chan === 2'd2 && busy === 1'b1))
      $display("FAIL lat_ogreq got req=%b ch=%0d busy=%b want 1 2 1", og_req, og_chan, busy);
    else passed++;
    @(negedge clk);
    checks++;
    if (!(og_req === 1'b1 && ram_en === 1'b0))
      $display("FAIL lat_oghold got req=%b en=%b want 1 0", og_req, ram_en);
    else passed++;
    og_man = 1'b1;
    @(negedge clk);
    og_man = 1'b0;
    @(negedge clk);
    checks++;
    if (!(ram_en === 1'b1 && ram_addr === 4'd0))
      $display("FAIL lat_ram got en=%b addr=%0d want 1 0", ram_en, ram_addr);
    else passed++;
    @(negedge clk);
    checks++;
    if (tx_valid !== 1'b0) $display("FAIL lat_cap got tx_valid=%b want 0", tx_valid);
    else passed++;
    @(negedge clk);
    checks++;
    if (!(tx_valid === 1'b1 && tx_data === corr(mem[2][0], off_tab[2], gain_tab[2])))
      $display("FAIL lat_tx got v=%b d=%h want 1 %h", tx_valid, tx_data,
               corr(mem[2][0], off_tab[2], gain_tab[2]));
    else passed++;
    repeat (3) @(negedge clk);
    checks++;
    if (tx_valid !== 1'b1) $display("FAIL lat_hold got tx_valid=%b want 1", tx_valid);
    else passed++;
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checks++;
    if ({busy, tx_valid} !== 2'b00)
      $display("FAIL lat_abort got busy/valid=%b want 00", {busy, tx_valid});
    else passed++;
    repeat (2) @(negedge clk);
    checks++;
    if (done_cnt !== 0) $display("FAIL lat_nodone got %0d want 0", done_cnt);
    else passed++;
    og_auto = 1'b1;
  endtask

  task automatic test_single();
    fill_pattern();
    off_tab[1] = 8'h00;
    gain_tab[1] = 8'h80;
    rdy_mode = 0;
    run_dump(1'b0, 2'd1, 4'd5, "single");
    checks++;
    if (got.size() !== 16) $display("FAIL single_count got %0d want 16", got.size());
    else passed++;
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (i >= got.size() || got[i] !== 8'(8'h10 + ((6 + i) % 16)))
        $display("FAIL single_s%0d got %h want %h", i, (i < got.size()) ? got[i] : 8'hxx,
                 8'(8'h10 + ((6 + i) % 16)));
      else passed++;
    end
    checks++;
    if (done_cnt !== 1) $display("FAIL single_done got %0d want 1", done_cnt);
    else passed++;
    checks++;
    if (busy !== 1'b0) $display("FAIL single_busy got %b want 0", busy);
    else passed++;
  endtask

  task automatic test_saturation();
    logic [7:0] vr [4] = '{8'hF0, 8'h10, 8'h40, 8'h90};
    logic [7:0] vo [4] = '{8'h20, 8'hE0, 8'h00, 8'h00};
    logic [7:0] vg [4] = '{8'h80, 8'h80, 8'h40, 8'hFF};
    logic [7:0] ve [4] = '{8'hFF, 8'h00, 8'h20, 8'hFF};
    rdy_mode = 0;
    for (int k = 0; k < 4; k++) begin
      for (int a = 0; a < 16; a++) mem[0][a] = vr[k];
      off_tab[0]  = vo[k];
      gain_tab[0] = vg[k];
      run_dump(1'b0, 2'd0, 4'd0, "sat");
      checks++;
      if (got.size() !== 16) $display("FAIL sat%0d_count got %0d want 16", k, got.size());
      else passed++;
      checks++;
      if (got.size() == 0 || got[0] !== ve[k] || got[got.size()-1] !== ve[k])
        $display("FAIL sat%0d_val got %h want %h", k, (got.size() > 0) ? got[0] : 8'hxx, ve[k]);
      else passed++;
    end
  endtask

  task automatic test_dump_all(input int mode, input string tag);
    rdy_mode   = mode;
    chk_stable = (mode == 1);
    stab_err   = 0;
    run_dump(1'b1, 2'd1, 4'd10, tag);
    chk_stable = 1'b0;
    build_exp(1'b1, 1, 10);
    checks++;
    if (got.size() !== 48) $display("FAIL %s_count got %0d want 48", tag, got.size());
    else passed++;
    for (int i = 0; i < 48; i++) begin
      checks++;
      if (i >= got.size() || got[i] !== exp_q[i])
        $display("FAIL %s_s%0d got %h want %h", tag, i, (i < got.size()) ? got[i] : 8'hxx, exp_q[i]);
      else passed++;
    end
    checks++;
    if (!(og_log.size() == 3 && og_log[0] == 0 && og_log[1] == 1 && og_log[2] == 2))
      $display("FAIL %s_ogseq got n=%0d want 3 req 0,1,2", tag, og_log.size());
    else passed++;
    checks++;
    if (done_cnt !== 1) $display("FAIL %s_done got %0d want 1", tag, done_cnt);
    else passed++;
    checks++;
    if (stab_err !== 0) $display("FAIL %s_stable got %0d want 0", tag, stab_err);
    else passed++;
  endtask

  task automatic test_abort();
    int n;
    fill_pattern();
    rdy_mode = 3;
    got.delete();
    done_cnt = 0;
    @(negedge clk);
    dump_start = 1'b1;
    dump_all   = 1'b0;
    dump_chan  = 2'd0;
    trace_end  = 4'd3;
    @(negedge clk);
    dump_start = 1'b0;
    n = 0;
    while (!(tx_valid && got.size() == 7) && n < 500) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!(tx_valid && got.size() == 7))
      $display("FAIL abort_reach got v=%b n=%0d want 1 7", tx_valid, got.size());
    else passed++;
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checks++;
    if ({busy, tx_valid, og_req, ram_en} !== 4'b0)
      $display("FAIL abort_idle got %b want 0000", {busy, tx_valid, og_req, ram_en});
    else passed++;
    repeat (3) @(negedge clk);
    checks++;
    if (done_cnt !== 0 || got.size() !== 7)
      $display("FAIL abort_nodone got done=%0d n=%0d want 0 7", done_cnt, got.size());
    else passed++;
    @(negedge clk);
    dump_start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    dump_start = 1'b0;
    abort = 1'b0;
    checks++;
    if (busy !== 1'b0) $display("FAIL abort_vs_start got busy=%b want 0", busy);
    else passed++;
    rdy_mode = 0;
    run_dump(1'b0, 2'd3, 4'd7, "restart");
    build_exp(1'b0, 3, 7);
    checks++;
    if (got.size() !== 16) $display("FAIL restart_count got %0d want 16", got.size());
    else passed++;
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (i >= got.size() || got[i] !== exp_q[i])
        $display("FAIL restart_s%0d got %h want %h", i, (i < got.size()) ? got[i] : 8'hxx, exp_q[i]);
      else passed++;
    end
    checks++;
    if (done_cnt !== 1) $display("FAIL restart_done got %0d want 1", done_cnt);
    else passed++;
  endtask

  task automatic test_reset_restart();
    int n;
    fill_pattern();
    rdy_mode = 0;
    @(negedge clk);
    dump_start = 1'b1;
    dump_all   = 1'b0;
    dump_chan  = 2'd2;
    trace_end  = 4'd2;
    @(negedge clk);
    dump_start = 1'b0;
    repeat (20) @(negedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({og_req, ram_en, tx_valid, busy, done, tx_data, ram_addr, cur_chan} !== '0)
      $display("FAIL async_rst got %h want 0",
               {og_req, ram_en, tx_valid, busy, done, tx_data, ram_addr, cur_chan});
    else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    got.delete();
    og_log.delete();
    done_cnt = 0;
    dump_start = 1'b1;
    dump_all   = 1'b0;
    dump_chan  = 2'd1;
    trace_end  = 4'd5;
    @(negedge clk);
    dump_start = 1'b0;
    repeat (10) @(negedge clk);
    dump_start = 1'b1;
    dump_all   = 1'b1;
    dump_chan  = 2'd2;
    trace_end  = 4'd9;
    @(negedge clk);
    dump_start = 1'b0;
    n = 0;
    while (busy && n < 1000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (busy) $display("FAIL ign_timeout busy=%b want 0", busy);
    else passed++;
    @(negedge clk);
    build_exp(1'b0, 1, 5);
    checks++;
    if (got.size() !== 16 || og_log.size() !== 1 || done_cnt !== 1)
      $display("FAIL ign_shape got n=%0d og=%0d done=%0d want 16 1 1",
               got.size(), og_log.size(), done_cnt);
    else passed++;
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (i >= got.size() || got[i] !== exp_q[i])
        $display("FAIL ign_s%0d got %h want %h", i, (i < got.size()) ? got[i] : 8'hxx, exp_q[i]);
      else passed++;
    end
  endtask

  initial begin
    off_tab[0]  = 8'h00;
    gain_tab[0] = 8'h80;
    off_tab[1]  = 8'h05;
    gain_tab[1] = 8'h40;
    off_tab[2]  = 8'hFD;
    gain_tab[2] = 8'hA0;
    fill_pattern();
    test_reset();
    test_latency();
    test_single();
    test_saturation();
    off_tab[0]  = 8'h00;
    gain_tab[0] = 8'h80;
    off_tab[1]  = 8'h05;
    gain_tab[1] = 8'h40;
    fill_pattern();
    test_dump_all(0, "all");
    for (int c = 0; c < NCH; c++)
      for (int a = 0; a < 16; a++)
        mem[c][a] = 8'($urandom_range(0, 255));
    test_dump_all(1, "bp");
    test_abort();
    test_reset_restart();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
